// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: same-cycle hit, critical-word-first refill, per-index round-robin victims.
// A miss holds o_busy until the refill completes (ack waits + 2 cycles); memory throttles the refill with i_mem_ack.
module icache_nway #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int LINES       = 32,
  parameter int WAYS        = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_hit,
  output logic                  o_busy,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_ack
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, UPDATE = 2'd2} state_t;

  state_t                state;
  logic [TAG_W-1:0]      r_tag;
  logic [IDX_W-1:0]      r_idx;
  logic [OFF_W-1:0]      beat;
  logic [OFF_W-1:0]      cnt;
  logic [WAY_W-1:0]      victim;
  logic                  discard;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;

  logic [LINES-1:0]      valid      [WAYS];
  logic [WAY_W-1:0]      victim_ptr [LINES];
  logic [TAG_W-1:0]      tag_mem    [WAYS][LINES];
  logic [DATA_WIDTH-1:0] data_mem   [WAYS][LINES][BLOCK_WORDS];
  logic [DATA_WIDTH-1:0] line_buf   [BLOCK_WORDS];

  logic [OFF_W-1:0]      a_off;
  logic [IDX_W-1:0]      a_idx;
  logic [TAG_W-1:0]      a_tag;
  logic                  match_any;
  logic [DATA_WIDTH-1:0] inst_sel;
  logic [WAY_W-1:0]      victim_sel;
  logic                  hit;
  logic                  install;
  logic                  ack_take;
  logic [OFF_W-1:0]      beat_next;
  logic [WAY_W-1:0]      ptr_next;
  logic                  unused_addr_bits;

  assign a_off = i_addr[2 +: OFF_W];
  assign a_idx = i_addr[2 + OFF_W +: IDX_W];
  assign a_tag = i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused_addr_bits = ^i_addr[1:0];

  always_comb begin
    match_any = 1'b0;
    inst_sel  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][a_idx] && (tag_mem[w][a_idx] == a_tag)) begin
        match_any = 1'b1;
        inst_sel  = data_mem[w][a_idx][a_off];
      end
    end
    // Lowest-numbered free way wins; round-robin only once the set is full.
    victim_sel = victim_ptr[a_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][a_idx]) victim_sel = WAY_W'(w);
    end
  end

  // Reset gates the combinational outputs so they fall immediately with it.
  assign hit       = i_reset & i_rd & ~i_flush & (state == IDLE) & match_any;
  assign o_hit     = hit;
  assign o_inst    = hit ? inst_sel : '0;
  assign o_busy    = i_reset & ((state != IDLE) | (i_rd & ~hit));
  assign o_mem_rd  = mem_rd;
  assign o_mem_addr = mem_addr;

  assign install   = (state == UPDATE) & ~discard & ~i_flush;
  assign ack_take  = (state == FILL) & mem_rd & i_mem_ack;
  assign beat_next = beat + OFF_W'(1);
  assign ptr_next  = (victim_ptr[r_idx] == LAST_WAY) ? '0 : victim_ptr[r_idx] + WAY_W'(1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      r_tag    <= '0;
      r_idx    <= '0;
      beat     <= '0;
      cnt      <= '0;
      victim   <= '0;
      discard  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      for (int i = 0; i < LINES; i++) victim_ptr[i] <= '0;
    end else begin
      if (i_flush) begin
        for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      end
      case (state)
        IDLE: begin
          if (i_rd && !match_any && !i_flush) begin
            r_tag    <= a_tag;
            r_idx    <= a_idx;
            beat     <= a_off;
            cnt      <= '0;
            victim   <= victim_sel;
            discard  <= 1'b0;
            mem_rd   <= 1'b1;
            mem_addr <= {2'b00, a_tag, a_idx, a_off};
            state    <= FILL;
          end
        end
        FILL: begin
          // A flushed refill still drains on the bus; it is just never installed.
          if (i_flush) discard <= 1'b1;
          if (ack_take) begin
            beat     <= beat_next;
            cnt      <= cnt + OFF_W'(1);
            mem_addr <= {2'b00, r_tag, r_idx, beat_next};
            if (cnt == LAST_BEAT) begin
              mem_rd <= 1'b0;
              state  <= UPDATE;
            end
          end
        end
        UPDATE: begin
          if (install) begin
            valid[victim][r_idx] <= 1'b1;
            if (victim == victim_ptr[r_idx]) victim_ptr[r_idx] <= ptr_next;
          end
          discard <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (ack_take) line_buf[beat] <= i_mem_data;
    if (install) begin
      tag_mem[victim][r_idx] <= r_tag;
      for (int b = 0; b < BLOCK_WORDS; b++) data_mem[victim][r_idx][b] <= line_buf[b];
    end
  end

endmodule
